// File: rtl/seri_alici.sv
// seri_alici: serial frame receiver (start 0, N data bits LSB first, stop 1) with framing-error pulse.
// Optional even-parity bit between data and stop when SERI_PARITE_EN is defined.
module seri_alici #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         x,
  output logic [N-1:0] Q,
  output logic         gecerli,
  output logic         hata,
  output logic         mesgul
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
`ifdef SERI_PARITE_EN
  typedef enum logic [1:0] {BOSTA, VERI, PARITE, DUR} state_t;
`else
  typedef enum logic [1:0] {BOSTA, VERI, DUR} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] sh_q, sh_d, q_q, q_d;
  logic gecerli_q, gecerli_d, hata_q, hata_d, ok;
`ifdef SERI_PARITE_EN
  logic par_ok_q, par_ok_d;
  assign ok = x & par_ok_q;
`else
  assign ok = x;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    q_d       = q_q;
    gecerli_d = 1'b0;
    hata_d    = 1'b0;
`ifdef SERI_PARITE_EN
    par_ok_d  = par_ok_q;
`endif
    if (en) begin
      unique case (state_q)
        BOSTA: begin
          state_d = x ? BOSTA : VERI;
          cnt_d   = '0;
        end
        VERI: begin
          sh_d[cnt_q] = x;
          cnt_d       = cnt_q + 1'b1;
`ifdef SERI_PARITE_EN
          state_d     = (cnt_q == CW'(N - 1)) ? PARITE : VERI;
`else
          state_d     = (cnt_q == CW'(N - 1)) ? DUR : VERI;
`endif
        end
`ifdef SERI_PARITE_EN
        PARITE: begin
          par_ok_d = ~(^sh_q ^ x);
          state_d  = DUR;
        end
`endif
        DUR: begin
          gecerli_d = ok;
          hata_d    = ~ok;
          q_d       = ok ? sh_q : q_q;
          state_d   = BOSTA;
        end
        default: state_d = BOSTA;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOSTA;
      cnt_q     <= '0;
      sh_q      <= '0;
      q_q       <= '0;
      gecerli_q <= 1'b0;
      hata_q    <= 1'b0;
`ifdef SERI_PARITE_EN
      par_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      q_q       <= q_d;
      gecerli_q <= gecerli_d;
      hata_q    <= hata_d;
`ifdef SERI_PARITE_EN
      par_ok_q  <= par_ok_d;
`endif
    end
  end
  assign Q       = q_q;
  assign gecerli = gecerli_q;
  assign hata    = hata_q;
  assign mesgul  = state_q != BOSTA;
endmodule

// File: tb/tb_seri_alici.sv
// tb_seri_alici: table-driven frames checked through a pulse scoreboard, plus reset/back-to-back/parity sequences.
module tb_seri_alici;
  localparam int N = 5;
`ifdef SERI_PARITE_EN
  localparam int FL = N + 3;
`else
  localparam int FL = N + 2;
`endif
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, x = 1'b1;
  logic [N-1:0] Q;
  logic gecerli, hata, mesgul;
  int nvec = 0, nerr = 0, cyc = 0, stamp = 0, t1 = 0;
  logic prev_pulse = 1'b0;
  typedef struct {logic err; logic [N-1:0] q;} exp_t;
  typedef struct {logic [N-1:0] w; logic stop; logic tog; logic err; logic [N-1:0] q;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tv[7];

  seri_alici #(.N(N)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x),
    .Q(Q), .gecerli(gecerli), .hata(hata), .mesgul(mesgul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every pulse must match the next expected frame outcome.
  always @(posedge clk) begin
    #1;
    if (gecerli || hata) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected pulse: gecerli=%b hata=%b with no frame pending", gecerli, hata);
      end else begin
        e = sb.pop_front();
        chk("pulse hata", {31'd0, hata}, {31'd0, e.err});
        chk("pulse gecerli", {31'd0, gecerli}, {31'd0, ~e.err});
        chk("Q at pulse", 32'(Q), 32'(e.q));
      end
      chk("pulse width", {31'd0, prev_pulse}, 32'd0);
    end
    prev_pulse = gecerli || hata;
  end

  task automatic step(input logic e_i, input logic b);
    en = e_i;
    x  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic stop, input logic tog,
                            input logic flip, input logic err, input logic [N-1:0] eq);
    logic [FL-1:0] bits;
    logic m;
    int busy;
    bits[0] = 1'b0;
    for (int i = 0; i < N; i++) bits[i+1] = w[i];
`ifdef SERI_PARITE_EN
    bits[N+1] = (^w) ^ flip;
`else
    if (flip) $display("note: parity flip ignored without parity");
`endif
    bits[FL-1] = stop;
    sb.push_back('{err, eq});
    busy = 0;
    for (int i = 0; i < FL; i++) begin
      step(1'b1, bits[i]);
      if (mesgul) busy++;
      if (i == FL - 1) begin
        chk("pulse latency", {31'd0, gecerli | hata}, 32'd1);
        stamp = cyc;
      end
      if (tog) begin
        m = mesgul;
        step(1'b0, ~bits[i]);
        chk("hold on en=0", {31'd0, mesgul}, {31'd0, m});
      end
    end
    chk("mesgul cycles", busy, FL - 1);
  endtask

  initial begin
    tv[0] = '{5'b01010, 1'b1, 1'b0, 1'b0, 5'b01010};
    tv[1] = '{5'b10011, 1'b1, 1'b1, 1'b0, 5'b10011};
    tv[2] = '{5'b11111, 1'b0, 1'b0, 1'b1, 5'b10011};
    tv[3] = '{5'b00000, 1'b1, 1'b1, 1'b0, 5'b00000};
    tv[4] = '{5'b10101, 1'b1, 1'b0, 1'b0, 5'b10101};
    tv[5] = '{5'b11100, 1'b0, 1'b1, 1'b1, 5'b10101};
    tv[6] = '{5'b00111, 1'b1, 1'b0, 1'b0, 5'b00111};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset Q", 32'(Q), 32'd0);
    chk("reset gecerli", {31'd0, gecerli}, 32'd0);
    chk("reset hata", {31'd0, hata}, 32'd0);
    chk("reset mesgul", {31'd0, mesgul}, 32'd0);
    reset = 1'b0;
    step(1'b1, 1'b1);
    chk("idle mesgul", {31'd0, mesgul}, 32'd0);
    send_frame(5'b01010, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000);
    for (int i = 0; i < 7; i++)
      send_frame(tv[i].w, tv[i].stop, tv[i].tog, 1'b0, tv[i].err, tv[i].q);
    send_frame(5'b10101, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10101);
    t1 = stamp;
    send_frame(5'b01100, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01100);
    chk("back-to-back spacing", stamp - t1, FL);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    chk("mid-frame mesgul", {31'd0, mesgul}, 32'd1);
    reset = 1'b1;
    step(1'b0, 1'b1);
    chk("mid reset mesgul", {31'd0, mesgul}, 32'd0);
    chk("mid reset Q", 32'(Q), 32'd0);
    chk("mid reset pulses", {30'd0, gecerli, hata}, 32'd0);
    reset = 1'b0;
    step(1'b1, 1'b1);
    send_frame(5'b00111, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111);
`ifdef SERI_PARITE_EN
    send_frame(5'b01010, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01010);
    send_frame(5'b01010, 1'b1, 1'b0, 1'b1, 1'b1, 5'b01010);
    send_frame(5'b10011, 1'b1, 1'b0, 1'b1, 1'b1, 5'b01010);
`endif
    repeat (4) step(1'b1, 1'b1);
    chk("scoreboard drained", sb.size(), 0);
    chk("final idle", {31'd0, mesgul}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seri_alici.md
SERI_ALICI -- requirements
Module: seri_alici

Interface
REQ-001 Parameter: N, default 5, number of data bits per frame.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 en  input  1  bit-rate enable; one serial bit is sampled per clk edge where en=1.
REQ-005 x  input  1  serial line from upstream transmitter; idle level 1.
REQ-006 Q  output  N  last correctly received data word.
REQ-007 gecerli  output  1  one-clk pulse: new word loaded into Q.
REQ-008 hata  output  1  one-clk pulse: frame error detected.
REQ-009 mesgul  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be: start bit 0, N data bits LSB first, [parity bit, see REQ-022], stop bit 1.
REQ-011 The FSM SHALL have states BOSTA (idle), VERI (data), PARITE (parity, only with REQ-022) and DUR (stop).
REQ-012 State, bit counter and shift register SHALL change only on edges with en=1; with en=0 all of them hold indefinitely.
REQ-013 BOSTA: x=0 sampled -> VERI with bit counter=0; x=1 -> remain in BOSTA.
REQ-014 VERI: each enabled edge SHALL shift x into bit position [counter]; after bit N-1 -> PARITE (REQ-022) or DUR.
REQ-015 DUR, x=1 sampled: Q SHALL load the shift register and gecerli=1 for exactly the following clk cycle; next state is BOSTA.
REQ-016 DUR, x=0 sampled: hata=1 for exactly the following clk cycle, Q unchanged, gecerli stays 0; next state is BOSTA.
REQ-017 gecerli and hata SHALL be registered single-cycle pulses, deasserted on the next clk edge regardless of en, and never high together.
REQ-018 mesgul SHALL equal (state != BOSTA), decoded from the state register.
REQ-019 Back-to-back frames: a start bit sampled on the enabled edge right after the DUR edge SHALL be accepted with no gap.
REQ-020 Latency: the gecerli pulse starts on the edge that samples the stop bit, i.e. after N+2 enabled edges counted from the start-bit edge (N+3 with parity).

Reset
REQ-021 reset=1 SHALL force BOSTA, counter=0, shift register=0, Q=0, gecerli=0, hata=0, mesgul=0 at the next rising clk, regardless of en; reset mid-frame discards the partial frame with no pulse.

Configuration
REQ-022 Macro SERI_PARITE_EN:
- Defined: after VERI, state PARITE samples an even-parity bit (XOR of the data bits and the parity bit must equal 0), then goes to DUR.
- On a parity mismatch, the DUR edge SHALL pulse hata instead of gecerli, even if stop=1, and Q is unchanged.
- Undefined: the PARITE state and its logic are absent; the frame is exactly N+2 bits.

Verification
REQ-023 Bench SHALL cover:
- en=1, x sequence 0,0,1,0,1,0,1 (word 5'b01010) -> Q=5'b01010, one gecerli pulse after the 7th enabled edge, mesgul high for 6 cycles.
- Same frame with the stop bit as 0 -> hata pulse once; Q keeps its previous value (0 after reset); gecerli never asserts.
- en toggled 1/0 every clk during frame 5'b10011 -> Q=5'b10011; state holds on en=0 cycles; pulse width is 1 clk.
- reset=1 asserted after 3 data bits -> mesgul=0, Q=0 next cycle; a following full frame 5'b00111 is received correctly.
- Back-to-back frames 5'b10101 then 5'b01100 with no idle bits -> two gecerli pulses 7 enabled edges apart, Q holds each word in turn.
- SERI_PARITE_EN defined: frame 5'b01010 with parity bit 0 -> gecerli; same frame with parity bit 1 -> hata, Q unchanged.
